mem_access_stage: RTL and testbench

//  Memory stage of the multi-cycle pipeline. It consumes the effective address from the ALU stage
//  and performs the load or store against the data cache over a req/done handshake.

---
 rtl/mem_access_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage: launches loads/stores on the data cache over req/done, stalls upstream while busy,
// and extends load lanes. Optional MEM_MISALIGN_CHECK_EN traps misaligned half/word accesses.
module mem_access_stage #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              is_load_in,
   input  logic              is_store_in,
   input  logic              is_write_in,
   input  logic [1:0]        mem_size,
   input  logic              load_unsigned,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_W-1:0]  rd_in,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  rd_out,
   output logic              is_write_out,
   output logic              dc_req,
   output logic              dc_we,
   output logic [ADDR_W-1:0] dc_addr,
   output logic [DATA_W-1:0] dc_wdata,
   output logic [3:0]        dc_be,
`ifdef MEM_MISALIGN_CHECK_EN
   output logic              misalign_exc,
`endif
   input  logic              dc_done,
   input  logic [DATA_W-1:0] dc_rdata
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;
   localparam int unsigned BE_W  = 4;

   logic [0:0]        state_q, state_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        lane_q, lane_d;
   logic              unsigned_q, unsigned_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic              write_q, write_d;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [REG_W-1:0]  rd_out_q, rd_out_d;
   logic              is_write_out_q, is_write_out_d;
   logic              dc_req_q, dc_req_d;
   logic              dc_we_q, dc_we_d;
   logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
   logic [DATA_W-1:0] dc_wdata_q, dc_wdata_d;
   logic [BE_W-1:0]   dc_be_q, dc_be_d;
`ifdef MEM_MISALIGN_CHECK_EN
   logic              misalign_exc_q, misalign_exc_d;
`endif

   logic              mem_op_c;
   logic              misaligned_c;
   logic [BE_W-1:0]   be_c;
   logic [DATA_W-1:0] wdata_c;
   logic [7:0]        byte_c;
   logic [15:0]       half_c;
   logic [DATA_W-1:0] load_ext_c;

   // Incoming access decode: byte enables, replicated store data, alignment
   always_comb begin
      mem_op_c = in_valid & (is_load_in | is_store_in);
`ifdef MEM_MISALIGN_CHECK_EN
      misaligned_c = ((mem_size == 2'b01) & alu_result[0]) |
                     (mem_size[1] & (alu_result[1:0] != 2'b00));
`else
      misaligned_c = 1'b0;
`endif
      case (mem_size)
         2'b00: begin
            be_c    = 4'b0001 << alu_result[1:0];
            wdata_c = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << {alu_result[1], 1'b0};
            wdata_c = {2{store_data[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = store_data;
         end
      endcase
   end

   // Load lane selection and extension from the captured address/size
   always_comb begin
      byte_c = 8'(dc_rdata >> {lane_q, 3'b000});
      half_c = 16'(dc_rdata >> {lane_q[1], 4'b0000});
      case (size_q)
         2'b00:   load_ext_c = {{24{~unsigned_q & byte_c[7]}}, byte_c};
         2'b01:   load_ext_c = {{16{~unsigned_q & half_c[15]}}, half_c};
         default: load_ext_c = dc_rdata;
      endcase
   end

   assign stall = ~rst & ((state_q == S_IDLE) ? (mem_op_c & ~misaligned_c) : ~dc_done);

   // Next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      size_d         = size_q;
      lane_d         = lane_q;
      unsigned_d     = unsigned_q;
      rd_d           = rd_q;
      write_d        = write_q;
      out_valid_d    = 1'b0;
      wb_data_d      = wb_data_q;
      rd_out_d       = rd_out_q;
      is_write_out_d = is_write_out_q;
      dc_req_d       = dc_req_q;
      dc_we_d        = dc_we_q;
      dc_addr_d      = dc_addr_q;
      dc_wdata_d     = dc_wdata_q;
      dc_be_d        = dc_be_q;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_exc_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (mem_op_c && !misaligned_c) begin
               state_d    = S_WAIT;
               size_d     = mem_size;
               lane_d     = alu_result[1:0];
               unsigned_d = load_unsigned;
               rd_d       = rd_in;
               write_d    = is_write_in;
               dc_req_d   = 1'b1;
               dc_we_d    = is_store_in;
               dc_addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
               dc_be_d    = is_store_in ? be_c : 4'b1111;
               if (is_store_in) begin
                  dc_wdata_d = wdata_c;
               end
`ifdef MEM_MISALIGN_CHECK_EN
            end else if (mem_op_c) begin
               out_valid_d    = 1'b1;
               misalign_exc_d = 1'b1;
               is_write_out_d = 1'b0;
               rd_out_d       = rd_in;
               wb_data_d      = DATA_W'(alu_result);
`endif
            end else if (in_valid) begin
               out_valid_d    = 1'b1;
               wb_data_d      = DATA_W'(alu_result);
               rd_out_d       = rd_in;
               is_write_out_d = is_write_in;
            end
         end
         S_WAIT: begin
            if (dc_done) begin
               state_d        = S_IDLE;
               dc_req_d       = 1'b0;
               out_valid_d    = 1'b1;
               rd_out_d       = rd_q;
               is_write_out_d = write_q & ~dc_we_q;
               if (!dc_we_q) begin
                  wb_data_d = load_ext_c;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         size_q         <= 2'b00;
         lane_q         <= 2'b00;
         unsigned_q     <= 1'b0;
         rd_q           <= '0;
         write_q        <= 1'b0;
         out_valid_q    <= 1'b0;
         wb_data_q      <= '0;
         rd_out_q       <= '0;
         is_write_out_q <= 1'b0;
         dc_req_q       <= 1'b0;
         dc_we_q        <= 1'b0;
         dc_addr_q      <= '0;
         dc_wdata_q     <= '0;
         dc_be_q        <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
         misalign_exc_q <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         size_q         <= size_d;
         lane_q         <= lane_d;
         unsigned_q     <= unsigned_d;
         rd_q           <= rd_d;
         write_q        <= write_d;
         out_valid_q    <= out_valid_d;
         wb_data_q      <= wb_data_d;
         rd_out_q       <= rd_out_d;
         is_write_out_q <= is_write_out_d;
         dc_req_q       <= dc_req_d;
         dc_we_q        <= dc_we_d;
         dc_addr_q      <= dc_addr_d;
         dc_wdata_q     <= dc_wdata_d;
         dc_be_q        <= dc_be_d;
`ifdef MEM_MISALIGN_CHECK_EN
         misalign_exc_q <= misalign_exc_d;
`endif
      end
   end

   assign out_valid    = out_valid_q;
   assign wb_data      = wb_data_q;
   assign rd_out       = rd_out_q;
   assign is_write_out = is_write_out_q;
   assign dc_req       = dc_req_q;
   assign dc_we        = dc_we_q;
   assign dc_addr      = dc_addr_q;
   assign dc_wdata     = dc_wdata_q;
   assign dc_be        = dc_be_q;
`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign_exc = misalign_exc_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random traffic against a byte-lane arithmetic model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, is_load_in, is_store_in, is_write_in, load_unsigned;
   logic [1:0]  mem_size;
   logic [31:0] alu_result, store_data, dc_rdata;
   logic [4:0]  rd_in;
   logic        dc_done;
   logic        stall, out_valid, is_write_out, dc_req, dc_we;
   logic [31:0] wb_data, dc_addr, dc_wdata;
   logic [4:0]  rd_out;
   logic [3:0]  dc_be;
`ifdef MEM_MISALIGN_CHECK_EN
   logic        misalign_exc;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .is_load_in(is_load_in),
      .is_store_in(is_store_in), .is_write_in(is_write_in), .mem_size(mem_size),
      .load_unsigned(load_unsigned), .alu_result(alu_result), .store_data(store_data),
      .rd_in(rd_in), .stall(stall), .out_valid(out_valid), .wb_data(wb_data),
      .rd_out(rd_out), .is_write_out(is_write_out), .dc_req(dc_req), .dc_we(dc_we),
      .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be),
`ifdef MEM_MISALIGN_CHECK_EN
      .misalign_exc(misalign_exc),
`endif
      .dc_done(dc_done), .dc_rdata(dc_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access width in bytes, aligned lane offset, masks
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      int lo = int'(a % 4);
      return lo - (lo % n);
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      int n = nbytes(sz);
      logic [63:0] v = ((64'd1 << n) - 64'd1) << lane_off(sz, a);
      return 4'(v);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
      int n = nbytes(sz);
      logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
      logic [63:0] r = 64'd0;
      for (int i = 0; i < 4 / n; i++) r |= ({32'd0, d} & mask) << (8 * n * i);
      return 32'(r);
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                          input logic uns, input logic [31:0] rd);
      int n = nbytes(sz);
      logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
      logic [63:0] v = ({32'd0, rd} >> (8 * lane_off(sz, a))) & mask;
      if (!uns && v[8 * n - 1]) v |= ~mask;
      return 32'(v);
   endfunction

   function automatic logic m_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
      return (a % nbytes(sz)) != 0;
`else
      return (sz == 2'd3) && (a == 32'hFFFF_FFFF);
`endif
   endfunction

   task automatic run_alu(input logic [31:0] res, input logic [4:0] rd, input logic wr);
      in_valid = 1'b1; is_load_in = 1'b0; is_store_in = 1'b0;
      alu_result = res; rd_in = rd; is_write_in = wr;
      #1;
      chk("alu_stall", 32'(stall), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("alu_valid", 32'(out_valid), 32'd1);
      chk("alu_wb_data", wb_data, res);
      chk("alu_rd", 32'(rd_out), 32'(rd));
      chk("alu_write", 32'(is_write_out), 32'(wr));
      tick();
      chk("alu_pulse", 32'(out_valid), 32'd0);
   endtask

   task automatic run_mem(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int lat,
                          input logic [4:0] rd, input logic wr);
      logic mis;
      in_valid = 1'b1; is_load_in = ld; is_store_in = st; mem_size = sz;
      load_unsigned = uns; alu_result = addr; store_data = sdata; rd_in = rd; is_write_in = wr;
      mis = m_misalign(sz, addr) && (sz != 2'd0);
      #1;
      if (mis) begin
         chk("mis_stall", 32'(stall), 32'd0);
         tick();
         in_valid = 1'b0;
         chk("mis_valid", 32'(out_valid), 32'd1);
`ifdef MEM_MISALIGN_CHECK_EN
         chk("mis_exc", 32'(misalign_exc), 32'd1);
`endif
         chk("mis_wb_data", wb_data, addr);
         chk("mis_write", 32'(is_write_out), 32'd0);
         chk("mis_no_req", 32'(dc_req), 32'd0);
         tick();
         chk("mis_pulse", 32'(out_valid), 32'd0);
         return;
      end
      chk("acc_stall", 32'(stall), 32'd1);
      tick();
      chk("req_high", 32'(dc_req), 32'd1);
      chk("req_we", 32'(dc_we), 32'(st));
      chk("req_addr", dc_addr, addr & 32'hFFFF_FFFC);
      chk("req_be", 32'(dc_be), st ? 32'(m_be(sz, addr)) : 32'hF);
      if (st) chk("req_wdata", dc_wdata, m_wdata(sz, sdata));
      chk("req_no_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < lat; i++) begin
         chk("wait_stall", 32'(stall), 32'd1);
         tick();
         chk("wait_req", 32'(dc_req), 32'd1);
         chk("wait_addr", dc_addr, addr & 32'hFFFF_FFFC);
      end
      dc_done = 1'b1; dc_rdata = rdata;
      #1;
      chk("done_stall", 32'(stall), 32'd0);
      tick();
      dc_done = 1'b0; in_valid = 1'b0; dc_rdata = $urandom;
      chk("done_valid", 32'(out_valid), 32'd1);
      chk("done_req", 32'(dc_req), 32'd0);
      chk("done_rd", 32'(rd_out), 32'(rd));
      chk("done_write", 32'(is_write_out), st ? 32'd0 : 32'(wr));
      if (!st) chk("load_data", wb_data, m_load(sz, addr, uns, rdata));
      tick();
      chk("done_pulse", 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0; is_write_in = 1'b0;
      mem_size = 2'd0; load_unsigned = 1'b0; alu_result = '0; store_data = '0; rd_in = '0;
      dc_done = 1'b0; dc_rdata = '0;
      tick(); tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_req", 32'(dc_req), 32'd0);
      chk("rst_we", 32'(dc_we), 32'd0);
      chk("rst_write", 32'(is_write_out), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_addr", dc_addr, 32'd0);
      chk("rst_wdata", dc_wdata, 32'd0);
      chk("rst_be", 32'(dc_be), 32'd0);
      chk("rst_rd", 32'(rd_out), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
      chk("rst_exc", 32'(misalign_exc), 32'd0);
`endif
      rst = 1'b0;
      tick();

      run_alu(32'h1234, 5'd5, 1'b1);
      run_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 5'd7, 1'b1);
      run_mem(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0, 5'd8, 1'b1);
      run_mem(1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80FF_0000, 1, 5'd9, 1'b1);
      run_mem(1'b0, 1'b1, 2'd1, 1'b0, 32'h206, 32'hABCD, 32'h0, 1, 5'd10, 1'b1);
      run_mem(1'b1, 1'b1, 2'd0, 1'b0, 32'h301, 32'h5A, 32'h0, 0, 5'd11, 1'b1);
      run_mem(1'b1, 1'b0, 2'd3, 1'b0, 32'h400, 32'h0, 32'h8000_0001, 2, 5'd12, 1'b1);

      // Reset while waiting on the cache, then a stale done in IDLE
      in_valid = 1'b1; is_load_in = 1'b1; is_store_in = 1'b0; mem_size = 2'd2;
      alu_result = 32'h300; rd_in = 5'd3; is_write_in = 1'b1;
      tick();
      chk("pre_rst_req", 32'(dc_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_req", 32'(dc_req), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      dc_done = 1'b1; dc_rdata = 32'hCAFE_F00D;
      tick();
      dc_done = 1'b0;
      chk("stale_valid", 32'(out_valid), 32'd0);
      chk("stale_req", 32'(dc_req), 32'd0);
      run_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1357_9BDF, 1, 5'd3, 1'b1);

      // Misaligned word: trapped when checking is built in, otherwise aligned down
      run_mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h1122_3344, 1, 5'd4, 1'b1);
      run_mem(1'b1, 1'b0, 2'd1, 1'b0, 32'h105, 32'h0, 32'h1122_F344, 0, 5'd6, 1'b1);

      for (int k = 0; k < 60; k++) begin
         int op = int'($urandom_range(0, 2));
         logic st = (op == 2);
         logic ld = (op == 1) | (st & 1'($urandom_range(0, 1)));
         if (op == 0) run_alu($urandom, 5'($urandom), 1'($urandom));
         else run_mem(ld, st, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), 5'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
